rx_rdbus_arbiter: RTL

//  Round-robin scheduler for the shared tri-state LocalLink read bus of NFIFO rx client FIFOs.

---
 rtl/rx_rdbus_if.sv | 30 +++
 rtl/rx_rdbus_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/rx_rdbus_if.sv
// Shared LocalLink read bus of the rx client FIFOs plus the single downstream
// LocalLink sink, as seen by the read-bus arbiter.
interface rx_rdbus_if #(
  parameter int NFIFO = 4
);
  logic [4*NFIFO-1:0] fifo_status;
  logic [5:0]         rd_addr;
  logic               rd_dst_rdy_n;
  logic [7:0]         bus_data;
  logic               bus_sof_n;
  logic               bus_eof_n;
  logic               bus_src_rdy_n;
  logic [7:0]         out_data;
  logic               out_sof_n;
  logic               out_eof_n;
  logic               out_src_rdy_n;
  logic               out_dst_rdy_n;

  // arbiter side
  modport master (
    input  fifo_status, bus_data, bus_sof_n, bus_eof_n, bus_src_rdy_n, out_dst_rdy_n,
    output rd_addr, rd_dst_rdy_n, out_data, out_sof_n, out_eof_n, out_src_rdy_n
  );

  // FIFO bank / downstream sink side
  modport slave (
    output fifo_status, bus_data, bus_sof_n, bus_eof_n, bus_src_rdy_n, out_dst_rdy_n,
    input  rd_addr, rd_dst_rdy_n, out_data, out_sof_n, out_eof_n, out_src_rdy_n
  );
endinterface

// File: rtl/rx_rdbus_arbiter.sv
// Round-robin scheduler for the shared tri-state read bus of NFIFO rx FIFOs.
// Selects one FIFO per frame, forwards exactly one frame to the downstream
// sink, then idles the bus address long enough for the FIFO drivers to go Z.
module rx_rdbus_arbiter #(
  parameter int          NFIFO     = 4,
  parameter logic [5:0]  BASE_ADDR = 6'h3c,
  parameter logic [5:0]  IDLE_ADDR = 6'h00,
  parameter logic [15:0] TIMEOUT   = 16'd1023
) (
  input  logic       rd_clk,
  input  logic       rd_sreset_n,
  rx_rdbus_if.master bus,
  output logic [2:0] active_port,
  output logic       busy,
  output logic       frame_done,
  output logic       timeout_err
);

  typedef enum logic [1:0] {IDLE, SETTLE, XFER, RELEASE} state_t;

  state_t      state;
  logic [5:0]  rd_addr_q;
  logic [2:0]  rr_ptr;
  logic        phase;     // second cycle of SETTLE / RELEASE
  logic [15:0] tmo_cnt;   // consecutive XFER cycles without an accepted beat

  logic [7:0]  req;
  logic [2:0]  pick, cand;
  logic        req_any;
  logic        xfer, beat_ok;

  // Collapse each FIFO status nibble into a request bit
  always_comb begin
    req = '0;
    for (int i = 0; i < NFIFO; i++) req[i] = |bus.fifo_status[4*i +: 4];
  end

  // First requester after the rr pointer; scanning from the far end down lets
  // the nearest hit win without a priority break
  always_comb begin
    req_any = 1'b0;
    pick    = rr_ptr;
    cand    = '0;
    for (int k = NFIFO; k >= 1; k--) begin
      cand = 3'((int'(rr_ptr) + k) % NFIFO);
      if (req[cand]) begin
        req_any = 1'b1;
        pick    = cand;
      end
    end
  end

  assign xfer    = (state == XFER);
  assign beat_ok = xfer && !bus.bus_src_rdy_n && !bus.out_dst_rdy_n;

  // Frame scheduler: select, settle, transfer one frame, release the bus
  always_ff @(posedge rd_clk) begin
    if (!rd_sreset_n) begin
      state       <= IDLE;
      rd_addr_q   <= IDLE_ADDR;
      rr_ptr      <= 3'(NFIFO - 1);
      active_port <= '0;
      phase       <= 1'b0;
      tmo_cnt     <= '0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_any) begin
            active_port <= pick;
            rd_addr_q   <= BASE_ADDR + {3'b000, pick};
            phase       <= 1'b0;
            state       <= SETTLE;
          end
        end
        SETTLE: begin
          if (phase) begin
            phase   <= 1'b0;
            tmo_cnt <= '0;
            state   <= XFER;
          end else begin
            phase <= 1'b1;
          end
        end
        XFER: begin
          if (beat_ok && !bus.bus_eof_n) begin
            frame_done <= 1'b1;
            rr_ptr     <= active_port;
            rd_addr_q  <= IDLE_ADDR;
            state      <= RELEASE;
          end else if (beat_ok) begin
            tmo_cnt <= '0;
          end else if (tmo_cnt == TIMEOUT - 16'd1) begin
            timeout_err <= 1'b1;
            rr_ptr      <= active_port;
            rd_addr_q   <= IDLE_ADDR;
            state       <= RELEASE;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        RELEASE: begin
          if (phase) begin
            phase <= 1'b0;
            state <= IDLE;
          end else begin
            phase <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rd_addr = rd_addr_q;
  assign busy        = (state != IDLE);

  // Pass-through only while transferring so a floating bus never leaks downstream
  assign bus.rd_dst_rdy_n  = xfer ? bus.out_dst_rdy_n : 1'b1;
  assign bus.out_src_rdy_n = xfer ? bus.bus_src_rdy_n : 1'b1;
  assign bus.out_sof_n     = xfer ? bus.bus_sof_n     : 1'b1;
  assign bus.out_eof_n     = xfer ? bus.bus_eof_n     : 1'b1;
  assign bus.out_data      = xfer ? bus.bus_data      : 8'h00;

endmodule
